// File: rtl/target_select_pkg.sv
// Shared types and constants for the target-select transmitter: FSM state
// encoding, frame layout constants and the frame builder.
package target_select_pkg;

    localparam int FRAME_W = 8;
    localparam logic [1:0] CMD_TAG = 2'b11;
    localparam logic [FRAME_W-1:0] NULL_FRAME = 8'h00;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

    // Valid IDs sit above the two tag bits; out-of-range IDs send the null frame.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0] id,
                                                       input logic      in_range);
        return in_range ? {id, CMD_TAG} : NULL_FRAME;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser, stability counter and one-cycle settle strobe for
// the raw selector switches.
module switch_debouncer
    import target_select_pkg::*;
#(
    parameter int SW_W         = 5,
    parameter int DEBOUNCE_CNT = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] raw,
    output logic [SW_W-1:0] stable,
    output logic            settled
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SW_W-1:0]  sync0;
    logic [SW_W-1:0]  sync1;
    logic [CNT_W-1:0] cnt;
    logic             changed;

    // stable is the previous-cycle synchronised value.
    assign changed = (sync1 != stable);

    // Strobe fires only on the edge the counter reaches its limit, not while saturated.
    assign settled = !changed && (cnt == CNT_LAST);

    // NOTE: non-blocking assignments let sync0/sync1/stable form a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0  <= '0;
            sync1  <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync0  <= raw;
            sync1  <= sync0;
            stable <= sync1;
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/target_select_tx.sv
// Debounced machine-ID selector driving one-byte UART command frames.
// Optional idle resend compiled in with TARGET_SELECT_RESEND_EN.
module target_select_tx
    import target_select_pkg::*;
#(
    parameter int SW_W         = 5,
    parameter int DEBOUNCE_CNT = 5000000,
    parameter int MAX_ID       = 20,
    parameter int RESEND_CYC   = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SW_W-1:0]    select_switches,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [FRAME_W-1:0] tx_data,
    output logic [SW_W-1:0]    target_id,
    output logic               id_valid
);

    if (SW_W < 1 || SW_W > 6) begin : g_bad_sw_w
        $error("target_select_tx: SW_W must be in 1..6");
    end
    if (RESEND_CYC < 1) begin : g_bad_resend
        $error("target_select_tx: RESEND_CYC must be at least 1");
    end

    logic [SW_W-1:0] stable;
    logic            settled;
    logic            first_commit;
    logic            commit;
    logic            pending;
    logic            resend_fire;
    logic            stable_ok;
    logic [SW_W-1:0] frame_id;
    logic            frame_ok;
    state_t          state;

    switch_debouncer #(
        .SW_W         (SW_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (select_switches),
        .stable  (stable),
        .settled (settled)
    );

    assign commit    = settled && ((stable != target_id) || first_commit);
    assign stable_ok = (32'(stable) <= MAX_ID);
    // target_id updates on the same edge, so a fresh commit frames the new value directly.
    assign frame_id  = commit ? stable : target_id;
    assign frame_ok  = (32'(frame_id) <= MAX_ID);
    assign tx_valid  = (state == ST_SEND);

`ifdef TARGET_SELECT_RESEND_EN
    localparam int TMR_W = $clog2(RESEND_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESEND_CYC - 1);

    logic [TMR_W-1:0] idle_timer;

    assign resend_fire = (state == ST_IDLE) && !first_commit && !pending && !commit
                         && (idle_timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_timer <= '0;
        else if (state != ST_IDLE || commit || pending || first_commit || resend_fire)
            idle_timer <= '0;
        else
            idle_timer <= idle_timer + 1'b1;
    end
`else
    assign resend_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tx_data      <= NULL_FRAME;
            target_id    <= '0;
            id_valid     <= 1'b0;
            pending      <= 1'b0;
            first_commit <= 1'b1;
        end else begin
            if (commit) begin
                target_id    <= stable;
                id_valid     <= stable_ok;
                first_commit <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (commit || pending || resend_fire) begin
                        state   <= ST_SEND;
                        tx_data <= build_frame(6'(frame_id), frame_ok);
                        pending <= 1'b0;
                    end
                end
                default: begin
                    // The frame in flight stays untouched; a newer commit waits for IDLE.
                    if (commit)
                        pending <= 1'b1;
                    if (tx_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_select_tx.sv
// Scoreboard bench for target_select_tx (DEBOUNCE_CNT=4, SW_W=5, MAX_ID=20,
// RESEND_CYC=10); the resend checks run when TARGET_SELECT_RESEND_EN is defined.
module tb_target_select_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sw;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [4:0] target_id;
    logic       id_valid;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         hs_count = 0;
    int         resend_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_frame = 8'h00;

    target_select_tx #(
        .SW_W         (5),
        .DEBOUNCE_CNT (4),
        .MAX_ID       (20),
        .RESEND_CYC   (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .select_switches (sw),
        .tx_ready        (tx_ready),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .target_id       (target_id),
        .id_valid        (id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_frame(input int id);
        logic [4:0] id5;
        id5 = 5'(id);
        return (id <= 20) ? {1'b0, id5, 2'b11} : 8'h00;
    endfunction

    // Monitor: every cycle with tx_valid must present the frame at the head of the queue.
    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            if ((exp_q.size() == 0 || exp_q[0] != tx_data) && tx_data == last_frame
                && `ifdef TARGET_SELECT_RESEND_EN 1'b1 `else 1'b0 `endif) begin
                if (tx_ready) resend_cnt++;
            end else if (exp_q.size() == 0) begin
                check("no_frame_expected", 32'(tx_valid), 0);
            end else begin
                check("frame_data", 32'(tx_data), 32'(exp_q[0]));
                if (tx_ready) begin
                    last_frame = exp_q.pop_front();
                    hs_count++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 100) begin
            step();
            n++;
        end
        if (!tx_valid) check(tag, 32'(tx_valid), 1);
    endtask

    initial begin
        int n;
        int hs0;
        int rs0;
        sw = 5'd0;
        tx_ready = 1'b1;
        rst_n = 1'b1;

        // Reset state, including outputs held while reset stays low
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_target_id", 32'(target_id), 0);
        check("rst_id_valid", 32'(id_valid), 0);
        idle(3);
        check("rst_hold_tx_valid", 32'(tx_valid), 0);

        // First debounced value goes out even though it is 0
        exp_q.push_back(exp_frame(0));
        @(negedge clk) rst_n = 1'b1;
        wait_drain("boot_frame_timeout");
        check("boot_target_id", 32'(target_id), 0);
        check("boot_id_valid", 32'(id_valid), 1);
        idle(20);

        // 0 -> 5: latency 2 sync + 4 count + 1, single handshake
        hs0 = hs_count;
        exp_q.push_back(exp_frame(5));
        sw = 5'd5;
        n = 0;
        do begin
            step();
            n++;
        end while (!(tx_valid && tx_data == 8'h17) && n < 30);
        check("latency_0_to_5", n, 7);
        wait_drain("id5_timeout");
        idle(20);
        check("one_handshake", hs_count - hs0, 1);
        check("id5_target_id", 32'(target_id), 5);
        check("id5_id_valid", 32'(id_valid), 1);

        // Out-of-range ID sends the null frame
        exp_q.push_back(exp_frame(25));
        sw = 5'd25;
        wait_drain("id25_timeout");
        idle(2);
        check("id25_target_id", 32'(target_id), 25);
        check("id25_id_valid", 32'(id_valid), 0);
        exp_q.push_back(exp_frame(5));
        sw = 5'd5;
        wait_drain("back_to_5_timeout");
        idle(10);

        // 3-cycle glitch to 9 never commits
        hs0 = hs_count;
        sw = 5'd9;
        idle(3);
        sw = 5'd5;
        idle(20);
        check("glitch_no_frame", hs_count - hs0, 0);
        check("glitch_target_id", 32'(target_id), 5);

        // Back-pressure: 1F held, 12 pending, then 33 after the handshake
        tx_ready = 1'b0;
        exp_q.push_back(exp_frame(7));
        sw = 5'd7;
        wait_valid("id7_valid_timeout");
        exp_q.push_back(exp_frame(12));
        sw = 5'd12;
        idle(15);
        check("pending_target_id", 32'(target_id), 12);
        check("held_tx_valid", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        wait_drain("backpressure_timeout");
        idle(20);

        // Reset mid-SEND aborts asynchronously; only the first-commit frame follows
        tx_ready = 1'b0;
        exp_q.push_back(exp_frame(3));
        sw = 5'd3;
        wait_valid("id3_valid_timeout");
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", 32'(tx_valid), 0);
        check("abort_tx_data", 32'(tx_data), 0);
        check("abort_target_id", 32'(target_id), 0);
        exp_q.delete();
        idle(2);
        exp_q.push_back(exp_frame(3));
        tx_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_drain("post_abort_timeout");
        check("post_abort_target_id", 32'(target_id), 3);
        idle(20);

`ifdef TARGET_SELECT_RESEND_EN
        rs0 = resend_cnt;
        idle(45);
        check("resend_repeats", 32'(resend_cnt - rs0 >= 3), 1);
        wait_valid("resend_valid_timeout");
        rst_n = 1'b0;
        #1;
        check("resend_abort_tx_valid", 32'(tx_valid), 0);
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
